// File: rtl/key_conditioner_pkg.sv
// Shared FSM state encoding and default timing for the push-button conditioner.
// Defaults assume the 50 MHz board clock.
package key_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } key_state_e;

  localparam bit DEF_ACTIVE_LOW   = 1'b1;
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int DEF_LONG_CYC     = 50_000_000;
  localparam int DEF_REPEAT_CYC   = 12_500_000;
  localparam int DEF_CNT_W        = 26;

endpackage

// File: rtl/key_conditioner_debounce_filter.sv
// Two-flop synchronizer followed by a consecutive-sample debounce filter.
// stable only changes after DEBOUNCE_CYC samples in a row disagree with it.
module debounce_filter
  import key_conditioner_pkg::*;
#(
  parameter bit ACTIVE_LOW   = DEF_ACTIVE_LOW,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic iCLK_50,
  input  logic reset_n,
  input  logic key_raw,
  output logic stable
);

  localparam logic IDLE_PIN = ACTIVE_LOW;

  logic             sync1;
  logic             sync2;
  logic             key_s;
  logic [CNT_W-1:0] deb_cnt;

  // Reset to the released pin level so leaving reset never looks like a press.
  always_ff @(posedge iCLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign key_s = sync2 ^ IDLE_PIN;

  always_ff @(posedge iCLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt <= '0;
      stable  <= 1'b0;
    end else if (key_s == stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
      stable  <= key_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: debounced level plus press / short / long / repeat pulses.
// The classifier acts on edges of the debounced level, so a key held across iEN low stays silent.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter bit ACTIVE_LOW   = DEF_ACTIVE_LOW,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic iCLK_50,
  input  logic reset_n,
  input  logic iKEY,
  input  logic iEN,
  output logic oLevel,
  output logic oPress,
  output logic oShort,
  output logic oLong,
  output logic oRepeat
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  key_state_e       state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [CNT_W-1:0] rep_cnt, rep_nxt;
  logic             stable, stable_d;
  logic             rose, fell;
  logic             press_nxt, short_nxt, long_nxt, repeat_nxt;

  debounce_filter #(
    .ACTIVE_LOW  (ACTIVE_LOW),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_debounce (
    .iCLK_50(iCLK_50),
    .reset_n(reset_n),
    .key_raw(iKEY),
    .stable (stable)
  );

  assign oLevel = stable;
  assign rose   = stable & ~stable_d;
  assign fell   = ~stable & stable_d;

  always_ff @(posedge iCLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      stable_d <= 1'b0;
      oPress   <= 1'b0;
      oShort   <= 1'b0;
      oLong    <= 1'b0;
      oRepeat  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      rep_cnt  <= rep_nxt;
      stable_d <= stable;
      oPress   <= press_nxt;
      oShort   <= short_nxt;
      oLong    <= long_nxt;
      oRepeat  <= repeat_nxt;
    end
  end

  // Release is tested before the long threshold so a same-cycle tie counts as a short press.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    rep_nxt   = rep_cnt;
    if (!iEN) begin
      state_nxt = IDLE;
      hold_nxt  = '0;
      rep_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          hold_nxt = '0;
          rep_nxt  = '0;
          if (rose) state_nxt = HELD;
        end
        HELD: begin
          if (fell) begin
            state_nxt = IDLE;
          end else if (hold_cnt == LONG_LAST) begin
            state_nxt = LONG;
            rep_nxt   = '0;
          end else begin
            hold_nxt = hold_cnt + CNT_W'(1);
          end
        end
        LONG: begin
          if (fell) state_nxt = IDLE;
          else if (rep_cnt == REPEAT_LAST) rep_nxt = '0;
          else rep_nxt = rep_cnt + CNT_W'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    press_nxt  = 1'b0;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    if (iEN) begin
      case (state)
        IDLE:    press_nxt = rose;
        HELD: begin
          short_nxt = fell;
          long_nxt  = ~fell && (hold_cnt == LONG_LAST);
        end
        LONG:    repeat_nxt = ~fell && (rep_cnt == REPEAT_LAST);
        default: press_nxt = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios then random presses, every cycle
// compared against an elapsed-time model of the debounce and press classification rules.
module tb_key_conditioner;

  localparam bit ACTIVE_LOW   = 1'b1;
  localparam int DEBOUNCE_CYC = 4;
  localparam int LONG_CYC     = 16;
  localparam int REPEAT_CYC   = 8;
  localparam int CNT_W        = 8;

  logic iCLK_50 = 1'b0;
  logic reset_n;
  logic iKEY;
  logic iEN;
  logic oLevel, oPress, oShort, oLong, oRepeat;

  int errors = 0;
  int checks = 0;

  // Reference model state: debounce window of pressed samples and press timing.
  logic win[$];
  logic m_stable, m_stable_d;
  bit   m_active;
  int   m_cycle, m_press_cyc, m_long_cyc;
  logic exp_level, exp_press, exp_short, exp_long, exp_repeat;

  key_conditioner #(
    .ACTIVE_LOW  (ACTIVE_LOW),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .LONG_CYC    (LONG_CYC),
    .REPEAT_CYC  (REPEAT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .iCLK_50(iCLK_50),
    .reset_n(reset_n),
    .iKEY   (iKEY),
    .iEN    (iEN),
    .oLevel (oLevel),
    .oPress (oPress),
    .oShort (oShort),
    .oLong  (oLong),
    .oRepeat(oRepeat)
  );

  always #5 iCLK_50 = ~iCLK_50;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s at model cycle %0d: observed=%b expected=%b", tag, m_cycle, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  task automatic modelReset();
    win.delete();
    for (int i = 0; i < DEBOUNCE_CYC + 1; i++) win.push_back(1'b0);
    m_stable    = 1'b0;
    m_stable_d  = 1'b0;
    m_active    = 1'b0;
    m_press_cyc = 0;
    m_long_cyc  = -1;
    exp_level   = 1'b0;
    exp_press   = 1'b0;
    exp_short   = 1'b0;
    exp_long    = 1'b0;
    exp_repeat  = 1'b0;
  endtask

  // One clock edge of the model; key/en are the values sampled at this edge.
  task automatic modelEdge(input logic key, input logic en);
    logic rose, fell, flip;
    rose       = m_stable & ~m_stable_d;
    fell       = ~m_stable & m_stable_d;
    exp_press  = 1'b0;
    exp_short  = 1'b0;
    exp_long   = 1'b0;
    exp_repeat = 1'b0;
    if (!en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (rose) begin
        m_active    = 1'b1;
        m_press_cyc = m_cycle;
        m_long_cyc  = -1;
        exp_press   = 1'b1;
      end
    end else if (fell) begin
      exp_short = (m_long_cyc < 0);
      m_active  = 1'b0;
    end else if (m_long_cyc < 0) begin
      if (m_cycle - m_press_cyc == LONG_CYC) begin
        exp_long   = 1'b1;
        m_long_cyc = m_cycle;
      end
    end else if ((m_cycle - m_long_cyc) % REPEAT_CYC == 0) begin
      exp_repeat = 1'b1;
    end
    // Level flips once the synchronised key has disagreed for a full window.
    flip = 1'b1;
    for (int i = 0; i < DEBOUNCE_CYC; i++)
      if (win[i] == m_stable) flip = 1'b0;
    m_stable_d = m_stable;
    if (flip) m_stable = ~m_stable;
    win.push_back(ACTIVE_LOW ? ~key : key);
    void'(win.pop_front());
    exp_level = m_stable;
    m_cycle++;
  endtask

  task automatic applyStimulus(input logic key, input logic en, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      iKEY = key;
      iEN  = en;
      @(posedge iCLK_50);
      #1;
      modelEdge(key, en);
      checkOutput("oLevel", oLevel, exp_level);
      checkOutput("oPress", oPress, exp_press);
      checkOutput("oShort", oShort, exp_short);
      checkOutput("oLong", oLong, exp_long);
      checkOutput("oRepeat", oRepeat, exp_repeat);
      checkOutput("onehot_pulses", $onehot0({oPress, oShort, oLong, oRepeat}), 1'b1);
      @(negedge iCLK_50);
    end
  endtask

  task automatic resetPulse();
    reset_n = 1'b0;
    #1;
    checkOutput("rst_oLevel", oLevel, 1'b0);
    checkOutput("rst_oPress", oPress, 1'b0);
    checkOutput("rst_oShort", oShort, 1'b0);
    checkOutput("rst_oLong", oLong, 1'b0);
    checkOutput("rst_oRepeat", oRepeat, 1'b0);
    modelReset();
    @(posedge iCLK_50);
    @(posedge iCLK_50);
    @(negedge iCLK_50);
    reset_n = 1'b1;
  endtask

  initial begin
    m_cycle = 0;
    iKEY    = 1'b1;
    iEN     = 1'b1;
    reset_n = 1'b1;
    @(negedge iCLK_50);
    resetPulse();
    applyStimulus(1'b1, 1'b1, 10);

    $display("[TB] glitch shorter than the debounce window");
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 12);

    $display("[TB] short press");
    applyStimulus(1'b0, 1'b1, 12);
    applyStimulus(1'b1, 1'b1, 14);

    $display("[TB] long press with auto-repeat");
    applyStimulus(1'b0, 1'b1, 60);
    applyStimulus(1'b1, 1'b1, 14);

    $display("[TB] release landing on the long threshold, then one cycle later");
    applyStimulus(1'b0, 1'b1, LONG_CYC);
    applyStimulus(1'b1, 1'b1, 14);
    applyStimulus(1'b0, 1'b1, LONG_CYC + 1);
    applyStimulus(1'b1, 1'b1, 14);

    $display("[TB] reset while in the long state");
    applyStimulus(1'b0, 1'b1, 30);
    resetPulse();
    applyStimulus(1'b0, 1'b1, 30);
    applyStimulus(1'b1, 1'b1, 14);

    $display("[TB] classifier disabled during a press, re-enabled while held");
    applyStimulus(1'b0, 1'b0, 30);
    applyStimulus(1'b1, 1'b0, 14);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 20);
    applyStimulus(1'b1, 1'b1, 14);

    $display("[TB] random presses, glitches and enable drops");
    for (int seg = 0; seg < 60; seg++) begin
      logic key_r, en_r;
      int   len;
      key_r = logic'($urandom_range(0, 1));
      en_r  = ($urandom_range(0, 7) != 0);
      len   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DEBOUNCE_CYC))
                                          : int'($urandom_range(1, 45));
      applyStimulus(key_r, en_r, len);
    end
    applyStimulus(1'b1, 1'b1, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
